// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word reads,
// buffers returned words and presents {pc, inst} to decode; redirects drop stale reads.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    input  logic        i_ready
);

    localparam int          PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int          CW  = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] pq_head_q, pq_head_d, pq_tail_q, pq_tail_d;

    logic [31:0] buf_pc_q   [BUF_DEPTH];
    logic [31:0] buf_inst_q [BUF_DEPTH];
    logic [31:0] pq_q       [BUF_DEPTH];

    logic          pop, accept, rsp, push;
    logic [CW:0]   credit;
    logic [1:0]    unused_rpc_bits;

    assign unused_rpc_bits = i_redirect_pc[1:0];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_valid     = (cnt_q != '0);
    assign o_pc        = o_valid ? buf_pc_q[head_q] : 32'h0;
    assign o_inst      = o_valid ? buf_inst_q[head_q] : NOP;
    assign o_imem_addr = fetch_pc_q;

    // Credit counts in-flight reads plus buffered words, so a granted read always has a slot.
    assign pop        = o_valid & i_ready;
    assign credit     = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
    assign o_imem_req = rst & ~i_redirect & (credit < (CW+1)'(BUF_DEPTH));
    assign accept     = o_imem_req & i_imem_gnt;
    assign rsp        = i_imem_rvalid & (out_q != '0);
    assign push       = rsp & (drop_q == '0) & ~i_redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        pq_head_d  = pq_head_q;
        pq_tail_d  = pq_tail_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pq_tail_d  = nxt(pq_tail_q);
        end
        if (accept && !rsp) out_d = out_q + CW'(1);
        if (!accept && rsp) out_d = out_q - CW'(1);

        // Dropped words belong to a flushed PC queue, so they must not pop it.
        if (rsp && drop_q != '0) drop_d = drop_q - CW'(1);
        if (rsp && drop_q == '0) pq_head_d = nxt(pq_head_q);

        if (push) tail_d = nxt(tail_q);
        if (pop)  head_d = nxt(head_q);
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
            drop_d     = out_d;
            cnt_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            pq_head_d  = '0;
            pq_tail_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            pq_head_q  <= '0;
            pq_tail_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pq_head_q  <= pq_head_d;
            pq_tail_q  <= pq_tail_d;
        end
    end

    // Storage needs no reset: occupancy is governed entirely by the pointers above.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[tail_q]   <= pq_q[pq_head_q];
            buf_inst_q[tail_q] <= i_imem_rdata;
        end
        if (accept) pq_q[pq_tail_q] <= fetch_pc_q;
    end

    a_rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst) i_imem_rvalid |-> (out_q != '0));

endmodule
